ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: the maximum number of consecutive data grants allowed while a fetch request is waiting.
REQ-002 SHALL have the following ports (name, direction, width, meaning):
- CLK  in  1  single clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iren  in  1  fetch read request.
- iaddr  in  32  fetch address.
- i_rdata  out  32  fetch read data.
- i_ram_busy  out  1  fetch request not yet completed.
- dren  in  1  data read request.
- dwen  in  1  data write request.
- daddr  in  32  data address.
- dwdata  in  32  data write value.
- dbyte_en  in  4  data byte enables.
- d_rdata  out  32  data read data.
- d_ram_busy  out  1  data request not yet completed.
- ram_ren  out  1  shared RAM port read strobe.
- ram_wen  out  1  shared RAM port write strobe.
- ram_addr  out  32  shared RAM port address.
- ram_wdata  out  32  shared RAM port write data.
- ram_byte_en  out  4  shared RAM port byte enables.
- ram_rdata  in  32  shared RAM port read data.
- ram_busy  in  1  RAM access in progress; 0 while a strobe is high means the access completes this cycle.

Function
REQ-003 SHALL implement an FSM with states IDLE, I_ACC and D_ACC.
REQ-004 In IDLE, grant selection SHALL be:
- data request (dren|dwen) with starve count < STARVE_LIMIT -> D_ACC;
- otherwise iren -> I_ACC;
- otherwise data request -> D_ACC;
- otherwise stay in IDLE.
REQ-005 On a grant, the block SHALL register ram_addr, ram_wdata, ram_byte_en, ram_ren and ram_wen from the granted requester, so the strobes are high from the cycle after the request is seen.
REQ-006 For fetch grants, the registered fields SHALL be ram_ren=1, ram_wen=0, ram_byte_en=4'hF and ram_wdata=0.
REQ-007 If dren and dwen are both high, the block SHALL issue a write only (ram_wen=1, ram_ren=0).
REQ-008 In I_ACC or D_ACC, the cycle with ram_busy=0 is the completion cycle; the next state SHALL be IDLE and the strobes SHALL clear on the following edge.
REQ-009 No re-arbitration SHALL occur in the completion cycle: there is exactly one IDLE bubble between accesses.
REQ-010 i_ram_busy SHALL equal iren AND NOT (state==I_ACC AND ram_busy==0); this is combinational.
REQ-011 d_ram_busy SHALL equal (dren|dwen) AND NOT (state==D_ACC AND ram_busy==0); this is combinational.
REQ-012 i_rdata SHALL equal ram_rdata when state==I_ACC, else 0; d_rdata SHALL equal ram_rdata when state==D_ACC and ram_wen==0, else 0.
REQ-013 Requesters hold the request and its fields stable until their busy output is low; the arbiter SHALL use the latched copy regardless.
REQ-014 If a requester drops its request mid-access, the access SHALL run to completion and the result SHALL be discarded; it SHALL NOT be aborted.
REQ-015 Starve counter, 3 bits, saturating at STARVE_LIMIT:
- increments on each D_ACC grant made while iren=1;
- clears on any I_ACC grant;
- clears on a D_ACC grant made while iren=0.
REQ-016 Minimum latency SHALL be 2 cycles from request to busy-low, occurring when ram_busy=0 in the first access cycle.
REQ-017 ram_busy SHALL be ignored in IDLE.

Reset
REQ-018 While nRST=0, regardless of the access in progress:
- state SHALL be IDLE;
- starve counter SHALL be 0;
- ram_ren, ram_wen, ram_addr, ram_wdata and ram_byte_en SHALL be 0;
- i_rdata and d_rdata SHALL be 0.
REQ-019 i_ram_busy and d_ram_busy SHALL follow REQ-010 and REQ-011 during reset, so they read 1 if a request is held high.
REQ-020 An access in progress when reset asserts SHALL be dropped with no completion signalled; the first grant SHALL be evaluated in the first cycle after nRST rises.

Verification
REQ-021 Single fetch: iren=1, iaddr=0x100, ram_busy low in the first access cycle, ram_rdata=0x00000013 -> ram_ren=1 and ram_addr=0x100 in cycle 1; i_ram_busy=0 and i_rdata=0x13 in cycle 1; ram_ren=0 in cycle 2.
REQ-022 Simultaneous request: iren=1 and dren=1 with daddr=0x2000 in the same cycle -> data served first; fetch issued after one IDLE bubble; i_ram_busy stays 1 throughout the data access.
REQ-023 Starvation: iren held high while the data side issues back-to-back requests, STARVE_LIMIT=4 -> four D_ACC grants, then an I_ACC grant; the counter reads 0 afterwards.
REQ-024 Write with wait states: dwen=1, daddr=0x3000, dwdata=0xDEADBEEF, dbyte_en=4'b0011, ram_busy high for 3 cycles -> ram_wen, address, data and byte enables stable for 4 cycles; d_ram_busy falls in the 4th; d_rdata=0.
REQ-025 dren=dwen=1 -> ram_wen=1 and ram_ren=0.
REQ-026 Reset mid-operation: nRST pulsed low during D_ACC with ram_busy=1 -> all RAM outputs 0 immediately (asynchronous); state IDLE; a held dren re-arbitrates in the cycle after release.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared RAM port. Data has
// priority until it has won STARVE_LIMIT grants in a row while a fetch waits.
module ram_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  // fetch port
  input  logic        iren,
  input  logic [31:0] iaddr,
  output logic [31:0] i_rdata,
  output logic        i_ram_busy,
  // data port
  input  logic        dren,
  input  logic        dwen,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dbyte_en,
  output logic [31:0] d_rdata,
  output logic        d_ram_busy,
  // shared RAM port
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_byte_en,
  input  logic [31:0] ram_rdata,
  input  logic        ram_busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIAcc = 2'd1,
    StDAcc = 2'd2
  } state_e;

  localparam logic [2:0] StarveMax = 3'(STARVE_LIMIT);

  state_e      state_q;
  logic [2:0]  starve_q;
  logic        ram_ren_q;
  logic        ram_wen_q;
  logic [31:0] ram_addr_q;
  logic [31:0] ram_wdata_q;
  logic [3:0]  ram_byte_en_q;

  logic        dreq;
  logic        d_first;
  logic        access_done;
  logic [2:0]  starve_inc;

  assign dreq        = dren | dwen;
  assign d_first     = dreq && (starve_q < StarveMax);
  assign access_done = (state_q != StIdle) && !ram_busy;
  assign starve_inc  = (starve_q < StarveMax) ? starve_q + 3'd1 : starve_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= StIdle;
      starve_q      <= 3'd0;
      ram_ren_q     <= 1'b0;
      ram_wen_q     <= 1'b0;
      ram_addr_q    <= 32'd0;
      ram_wdata_q   <= 32'd0;
      ram_byte_en_q <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (d_first || (dreq && !iren)) begin
            state_q       <= StDAcc;
            // A simultaneous read and write collapses to the write.
            ram_ren_q     <= dren & ~dwen;
            ram_wen_q     <= dwen;
            ram_addr_q    <= daddr;
            ram_wdata_q   <= dwdata;
            ram_byte_en_q <= dbyte_en;
            starve_q      <= iren ? starve_inc : 3'd0;
          end else if (iren) begin
            state_q       <= StIAcc;
            ram_ren_q     <= 1'b1;
            ram_wen_q     <= 1'b0;
            ram_addr_q    <= iaddr;
            ram_wdata_q   <= 32'd0;
            ram_byte_en_q <= 4'hF;
            starve_q      <= 3'd0;
          end
        end
        StIAcc, StDAcc: begin
          // Completion always returns to idle; the next grant waits one bubble.
          if (!ram_busy) begin
            state_q       <= StIdle;
            ram_ren_q     <= 1'b0;
            ram_wen_q     <= 1'b0;
            ram_addr_q    <= 32'd0;
            ram_wdata_q   <= 32'd0;
            ram_byte_en_q <= 4'd0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ram_ren     = ram_ren_q;
  assign ram_wen     = ram_wen_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_byte_en = ram_byte_en_q;

  assign i_ram_busy = iren & ~(access_done && (state_q == StIAcc));
  assign d_ram_busy = dreq & ~(access_done && (state_q == StDAcc));

  assign i_rdata = (state_q == StIAcc) ? ram_rdata : 32'd0;
  assign d_rdata = ((state_q == StDAcc) && !ram_wen_q) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a per-cycle vector table plus
// hand-written starvation and mid-access reset sequences.
module tb_ram_port_arbiter;

  logic        CLK;
  logic        nRST;
  logic        iren;
  logic [31:0] iaddr;
  logic [31:0] i_rdata;
  logic        i_ram_busy;
  logic        dren;
  logic        dwen;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dbyte_en;
  logic [31:0] d_rdata;
  logic        d_ram_busy;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_byte_en;
  logic [31:0] ram_rdata;
  logic        ram_busy;

  int checks = 0;
  int errors = 0;

  ram_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .iren       (iren),
    .iaddr      (iaddr),
    .i_rdata    (i_rdata),
    .i_ram_busy (i_ram_busy),
    .dren       (dren),
    .dwen       (dwen),
    .daddr      (daddr),
    .dwdata     (dwdata),
    .dbyte_en   (dbyte_en),
    .d_rdata    (d_rdata),
    .d_ram_busy (d_ram_busy),
    .ram_ren    (ram_ren),
    .ram_wen    (ram_wen),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_byte_en(ram_byte_en),
    .ram_rdata  (ram_rdata),
    .ram_busy   (ram_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dbe;
    logic        rbusy;
    logic [31:0] rdata;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_ibusy;
    logic        e_dbusy;
    logic [31:0] e_irdata;
    logic [31:0] e_drdata;
  } vec_t;

  localparam int NumVec = 19;
  vec_t vec [NumVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd, input logic [3:0] be,
                       input logic rb, input logic [31:0] rd);
    iren = ir; iaddr = ia; dren = dr; dwen = dw; daddr = da;
    dwdata = dd; dbyte_en = be; ram_busy = rb; ram_rdata = rd;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, " ram_ren"},     32'(ram_ren),     32'(v.e_ren));
    check({tag, " ram_wen"},     32'(ram_wen),     32'(v.e_wen));
    check({tag, " ram_addr"},    ram_addr,         v.e_addr);
    check({tag, " ram_wdata"},   ram_wdata,        v.e_wdata);
    check({tag, " ram_byte_en"}, 32'(ram_byte_en), 32'(v.e_be));
    check({tag, " i_ram_busy"},  32'(i_ram_busy),  32'(v.e_ibusy));
    check({tag, " d_ram_busy"},  32'(d_ram_busy),  32'(v.e_dbusy));
    check({tag, " i_rdata"},     i_rdata,          v.e_irdata);
    check({tag, " d_rdata"},     d_rdata,          v.e_drdata);
  endtask

  initial begin
    //          iren iaddr       dren dwen daddr       dwdata        dbe   rb  rdata
    //          ren  wen  addr        wdata         be    ibsy dbsy irdata      drdata
    // idle
    vec[0]  = '{0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,
                0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 32'h0,  32'h0};
    // single fetch, zero wait states
    vec[1]  = '{1, 32'h100, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,
                0, 0, 32'h0,    32'h0,        4'h0, 1, 0, 32'h0,  32'h0};
    vec[2]  = '{1, 32'h100, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h13,
                1, 0, 32'h100,  32'h0,        4'hF, 0, 0, 32'h13, 32'h0};
    // ram_busy ignored in idle
    vec[3]  = '{0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0, 1, 32'h13,
                0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 32'h0,  32'h0};
    // simultaneous fetch + data read: data first, fetch after one bubble
    vec[4]  = '{1, 32'h104, 1, 0, 32'h2000, 32'h0,        4'hF, 0, 32'h0,
                0, 0, 32'h0,    32'h0,        4'h0, 1, 1, 32'h0,  32'h0};
    vec[5]  = '{1, 32'h104, 1, 0, 32'h2000, 32'h0,        4'hF, 1, 32'hAAAA5555,
                1, 0, 32'h2000, 32'h0,        4'hF, 1, 1, 32'h0,  32'hAAAA5555};
    vec[6]  = '{1, 32'h104, 1, 0, 32'h2000, 32'h0,        4'hF, 0, 32'h12345678,
                1, 0, 32'h2000, 32'h0,        4'hF, 1, 0, 32'h0,  32'h12345678};
    vec[7]  = '{1, 32'h104, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,
                0, 0, 32'h0,    32'h0,        4'h0, 1, 0, 32'h0,  32'h0};
    vec[8]  = '{1, 32'h104, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h55,
                1, 0, 32'h104,  32'h0,        4'hF, 0, 0, 32'h55, 32'h0};
    vec[9]  = '{0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,
                0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 32'h0,  32'h0};
    // write with three wait states
    vec[10] = '{0, 32'h0,   0, 1, 32'h3000, 32'hDEADBEEF, 4'h3, 0, 32'h0,
                0, 0, 32'h0,    32'h0,        4'h0, 0, 1, 32'h0,  32'h0};
    vec[11] = '{0, 32'h0,   0, 1, 32'h3000, 32'hDEADBEEF, 4'h3, 1, 32'hFFFFFFFF,
                0, 1, 32'h3000, 32'hDEADBEEF, 4'h3, 0, 1, 32'h0,  32'h0};
    vec[12] = vec[11];
    vec[13] = vec[11];
    vec[14] = '{0, 32'h0,   0, 1, 32'h3000, 32'hDEADBEEF, 4'h3, 0, 32'hFFFFFFFF,
                0, 1, 32'h3000, 32'hDEADBEEF, 4'h3, 0, 0, 32'h0,  32'h0};
    vec[15] = vec[9];
    // read+write together issues a write only
    vec[16] = '{0, 32'h0,   1, 1, 32'h40,   32'h11,       4'hF, 0, 32'h99,
                0, 0, 32'h0,    32'h0,        4'h0, 0, 1, 32'h0,  32'h0};
    vec[17] = '{0, 32'h0,   1, 1, 32'h40,   32'h11,       4'hF, 0, 32'h99,
                0, 1, 32'h40,   32'h11,       4'hF, 0, 0, 32'h0,  32'h0};
    vec[18] = vec[9];

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset", vec[0]);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      @(negedge CLK);
      drive(vec[i].iren, vec[i].iaddr, vec[i].dren, vec[i].dwen, vec[i].daddr,
            vec[i].dwdata, vec[i].dbe, vec[i].rbusy, vec[i].rdata);
      #1;
      check_all($sformatf("vec%0d", i), vec[i]);
    end

    // Starvation: fetch held, data back-to-back, zero wait states. Each period is
    // four data grants then one fetch grant, each followed by an idle bubble.
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      drive(1, 32'h200, 1, 0, 32'h2000, 32'h0, 4'hF, 0, 32'h0);
      #1;
      if ((c % 2) == 1) begin
        check($sformatf("starve c%0d ram_ren", c), 32'(ram_ren), 32'd1);
        check($sformatf("starve c%0d ram_addr", c), ram_addr,
              ((c % 10) == 9) ? 32'h200 : 32'h2000);
      end else begin
        check($sformatf("starve c%0d ram_ren", c), 32'(ram_ren), 32'd0);
      end
    end
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a stalled data read.
    @(negedge CLK);
    drive(0, 0, 1, 0, 32'h500, 32'h0, 4'hF, 1, 32'hCAFEF00D);
    @(negedge CLK);
    #1;
    check("rst pre ram_ren", 32'(ram_ren), 32'd1);
    check("rst pre ram_addr", ram_addr, 32'h500);
    check("rst pre d_rdata", d_rdata, 32'hCAFEF00D);
    #1;
    nRST = 1'b0;
    #1;
    check("rst async ram_ren", 32'(ram_ren), 32'd0);
    check("rst async ram_addr", ram_addr, 32'h0);
    check("rst async ram_byte_en", 32'(ram_byte_en), 32'd0);
    check("rst async d_rdata", d_rdata, 32'h0);
    check("rst async d_ram_busy", 32'(d_ram_busy), 32'd1);
    check("rst async i_ram_busy", 32'(i_ram_busy), 32'd0);
    @(negedge CLK);
    #1;
    check("rst held ram_ren", 32'(ram_ren), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("rst rel ram_ren", 32'(ram_ren), 32'd0);
    check("rst rel d_ram_busy", 32'(d_ram_busy), 32'd1);
    @(negedge CLK);
    #1;
    check("rst regrant ram_ren", 32'(ram_ren), 32'd1);
    check("rst regrant ram_addr", ram_addr, 32'h500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
